// File: rtl/mapper_multicart_gen_pkg.sv
// Shared types and register decode constants for the multicart PRG/CHR mapper.
// The PRG banking modes, the CHR-RAM window base and the $5xxN IRQ register offsets live here.
package mapper_pkg;

  typedef enum logic [1:0] {
    PRG_32K  = 2'd0,
    PRG_128K = 2'd1,
    PRG_8K   = 2'd2,
    PRG_16K  = 2'd3
  } prg_mode_e;

  localparam logic [8:0] CHR_RAM_BASE = 9'b1_0000_0000;

  localparam logic [3:0] REG_PAGE_IRQ   = 4'h5;
  localparam logic [3:0] REG_PAGE_OUTER = 4'h6;
  localparam logic [3:0] REG_PAGE_CHR   = 4'h7;

  localparam logic [3:0] REG_IRQ_LO  = 4'h0;
  localparam logic [3:0] REG_IRQ_HI  = 4'h1;
  localparam logic [3:0] REG_IRQ_CTL = 4'h2;
  localparam logic [3:0] REG_IRQ_ACK = 4'h3;

endpackage

// File: rtl/mapper_multicart_gen_if.sv
// CPU/PPU-side bus bundle shared by the mappers: the bus decode drives master, the mapper is slave.
interface mapper_multicart_gen_if;
  logic        ce;
  logic [31:0] flags;
  logic [15:0] prg_ain;
  logic        prg_read;
  logic        prg_write;
  logic [7:0]  prg_din;
  logic [21:0] prg_aout;
  logic        prg_allow;
  logic [13:0] chr_ain;
  logic [21:0] chr_aout;
  logic        chr_allow;
  logic        vram_a10;
  logic        vram_ce;
  logic        irq;

  modport master (
    output ce, flags, prg_ain, prg_read, prg_write, prg_din, chr_ain,
    input  prg_aout, prg_allow, chr_aout, chr_allow, vram_a10, vram_ce, irq
  );

  modport slave (
    input  ce, flags, prg_ain, prg_read, prg_write, prg_din, chr_ain,
    output prg_aout, prg_allow, chr_aout, chr_allow, vram_a10, vram_ce, irq
  );
endinterface

// File: rtl/mapper_multicart_gen_irq_cnt.sv
// CPU-cycle IRQ down-counter: latch, counter, enable/reload control and a sticky level IRQ.
// A control write takes priority over the count step; a terminal count beats a same-cycle ack.
module mapper_irq_cnt
  import mapper_pkg::*;
#(
  parameter int IRQ_W = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ce,
  input  logic       we,
  input  logic [3:0] reg_a,
  input  logic [7:0] din,
  output logic       irq
);

  if (IRQ_W <= 8) begin : g_bad_irq_w
    $error("mapper_irq_cnt: IRQ_W must exceed 8");
  end

  logic [IRQ_W-1:0] irq_latch_r;
  logic [IRQ_W-1:0] irq_cnt_r;
  logic             irq_en_r;
  logic             irq_reload_r;
  logic             irq_r;

  logic wr_lo_s;
  logic wr_hi_s;
  logic wr_ctl_s;
  logic wr_ack_s;
  logic terminal_s;

  assign wr_lo_s    = we & (reg_a == REG_IRQ_LO);
  assign wr_hi_s    = we & (reg_a == REG_IRQ_HI);
  assign wr_ctl_s   = we & (reg_a == REG_IRQ_CTL);
  assign wr_ack_s   = we & (reg_a == REG_IRQ_ACK);
  assign terminal_s = ~wr_ctl_s & irq_en_r & (irq_cnt_r == IRQ_W'(1));

  // Latch/counter/flag update, one step per CPU cycle enable.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq_latch_r  <= {IRQ_W{1'b0}};
      irq_cnt_r    <= {IRQ_W{1'b0}};
      irq_en_r     <= 1'b0;
      irq_reload_r <= 1'b0;
      irq_r        <= 1'b0;
    end else if (ce) begin
      if (wr_lo_s) begin
        irq_latch_r[7:0] <= din;
      end
      if (wr_hi_s) begin
        irq_latch_r[IRQ_W-1:8] <= (IRQ_W-8)'(din);
      end

      // The counter reloads from the pre-write latch value, so latch writes only affect later reloads.
      if (wr_ctl_s) begin
        irq_en_r     <= din[0];
        irq_reload_r <= din[1];
        if (din[0]) begin
          irq_cnt_r <= irq_latch_r;
        end
      end else if (irq_en_r) begin
        if (irq_cnt_r == IRQ_W'(1)) begin
          if (irq_reload_r) begin
            irq_cnt_r <= irq_latch_r;
          end else begin
            irq_cnt_r <= {IRQ_W{1'b0}};
            irq_en_r  <= 1'b0;
          end
        end else begin
          irq_cnt_r <= irq_cnt_r - IRQ_W'(1);
        end
      end

      if (terminal_s) begin
        irq_r <= 1'b1;
      end else if (wr_ack_s) begin
        irq_r <= 1'b0;
      end
    end
  end

  assign irq = irq_r;

endmodule

// File: rtl/mapper_multicart_gen.sv
// Multicart PRG/CHR mapper: lockable outer block, inner PRG banking modes, CHR-ROM bank and
// a CPU-cycle IRQ counter. Address translation is combinational; only register state is clocked.
module mapper_multicart_gen
  import mapper_pkg::*;
#(
  parameter int PRG_BANK_W = 6,
  parameter int OUTER_W    = 2,
  parameter int CHR_BANK_W = 4,
  parameter int IRQ_W      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  mapper_multicart_gen_if.slave bus
);

  if (OUTER_W + PRG_BANK_W + 14 > 22) begin : g_bad_prg_w
    $error("mapper_multicart_gen: OUTER_W+PRG_BANK_W+14 must not exceed 22");
  end
  if (CHR_BANK_W > 8) begin : g_bad_chr_w
    $error("mapper_multicart_gen: CHR_BANK_W must not exceed 8");
  end

  prg_mode_e             mode_r;
  logic                  lowbit_r;
  logic                  mirr_r;
  logic [PRG_BANK_W-1:0] inner_r;
  logic [OUTER_W-1:0]    outer_r;
  logic                  lock_r;
  logic [CHR_BANK_W-1:0] chr_bank_r;

  logic                  wr_s;
  logic                  irq_we_s;
  logic [PRG_BANK_W:0]   prg_idx_s;
  logic                  unused_s;

  assign wr_s     = bus.ce & bus.prg_write;
  assign irq_we_s = wr_s & (bus.prg_ain[15:12] == REG_PAGE_IRQ);
  assign unused_s = ^{bus.prg_read, bus.flags[31:16], bus.flags[14:0]};

  // Banking registers; the outer block and CHR bank freeze once lock is set until reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_r     <= PRG_32K;
      lowbit_r   <= 1'b0;
      mirr_r     <= 1'b0;
      inner_r    <= {PRG_BANK_W{1'b0}};
      outer_r    <= {OUTER_W{1'b0}};
      lock_r     <= 1'b0;
      chr_bank_r <= {CHR_BANK_W{1'b0}};
    end else if (wr_s) begin
      if (bus.prg_ain[15]) begin
        mode_r   <= prg_mode_e'(bus.prg_ain[1:0]);
        lowbit_r <= bus.prg_din[7];
        mirr_r   <= bus.prg_din[6];
        inner_r  <= bus.prg_din[PRG_BANK_W-1:0];
      end else if (bus.prg_ain[15:12] == REG_PAGE_OUTER) begin
        if (!lock_r) begin
          outer_r <= bus.prg_din[OUTER_W-1:0];
          lock_r  <= bus.prg_din[7];
        end
      end else if (bus.prg_ain[15:12] == REG_PAGE_CHR) begin
        if (!lock_r) begin
          chr_bank_r <= bus.prg_din[CHR_BANK_W-1:0];
        end
      end
    end
  end

  // 8 KB PRG bank index within the current outer block.
  always_comb begin
    prg_idx_s = {inner_r, bus.prg_ain[13]};
    case (mode_r)
      PRG_32K: begin
        if (bus.prg_ain[14]) begin
          prg_idx_s = {inner_r | PRG_BANK_W'(1), bus.prg_ain[13]};
        end else begin
          prg_idx_s = {inner_r, bus.prg_ain[13]};
        end
      end
      PRG_128K: begin
        if (bus.prg_ain[14]) begin
          prg_idx_s = {{PRG_BANK_W{1'b1}}, bus.prg_ain[13]};
        end else begin
          prg_idx_s = {inner_r, bus.prg_ain[13]};
        end
      end
      PRG_8K:  prg_idx_s = {inner_r, lowbit_r};
      PRG_16K: prg_idx_s = {inner_r, bus.prg_ain[13]};
      default: prg_idx_s = {inner_r, bus.prg_ain[13]};
    endcase
  end

  assign bus.prg_aout  = 22'({outer_r, prg_idx_s, bus.prg_ain[12:0]});
  assign bus.prg_allow = bus.prg_ain[15] & ~bus.prg_write;

  assign bus.chr_aout  = bus.flags[15] ? {CHR_RAM_BASE, bus.chr_ain[12:0]}
                                       : (22'h20_0000 | 22'({chr_bank_r, bus.chr_ain[12:0]}));
  assign bus.chr_allow = bus.flags[15];
  assign bus.vram_a10  = mirr_r ? bus.chr_ain[11] : bus.chr_ain[10];
  assign bus.vram_ce   = bus.chr_ain[13];

  mapper_irq_cnt #(
    .IRQ_W (IRQ_W)
  ) u_irq_cnt (
    .clk   (clk),
    .reset (reset),
    .ce    (bus.ce),
    .we    (irq_we_s),
    .reg_a (bus.prg_ain[3:0]),
    .din   (bus.prg_din),
    .irq   (bus.irq)
  );

endmodule

// File: tb/tb_mapper_multicart_gen.sv
// Bench for mapper_multicart_gen: directed scenarios with fixed expected values, then random
// bus traffic compared against an arithmetic reference model of the mapper registers.
module tb_mapper_multicart_gen;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  // reference model state
  int m_mode, m_lowbit, m_mirr, m_inner, m_outer, m_lock, m_chr;
  int m_latch, m_cnt, m_en, m_rel, m_irq;

  always #5 clk = ~clk;

  mapper_multicart_gen_if bus();

  mapper_multicart_gen #(
    .PRG_BANK_W (6),
    .OUTER_W    (2),
    .CHR_BANK_W (4),
    .IRQ_W      (16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_lowbit = 0; m_mirr = 0; m_inner = 0; m_outer = 0; m_lock = 0; m_chr = 0;
    m_latch = 0; m_cnt = 0; m_en = 0; m_rel = 0; m_irq = 0;
  endtask

  task automatic model_apply(input int c, input int w, input int a, input int d);
    int old_latch;
    int page;
    int rg;
    if (c == 0) return;
    old_latch = m_latch;
    page = a / 4096;
    rg = a % 16;
    if (w != 0 && page == 5 && rg == 3) m_irq = 0;
    if (w != 0 && page == 5 && rg == 2) begin
      m_en = d % 2;
      m_rel = (d / 2) % 2;
      if (m_en == 1) m_cnt = old_latch;
    end else if (m_en == 1) begin
      if (m_cnt == 1) begin
        m_irq = 1;
        if (m_rel == 1) m_cnt = old_latch;
        else begin
          m_cnt = 0;
          m_en = 0;
        end
      end else begin
        m_cnt = (m_cnt + 65535) % 65536;
      end
    end
    if (w != 0) begin
      if (a >= 32768) begin
        m_mode = a % 4;
        m_lowbit = (d / 128) % 2;
        m_mirr = (d / 64) % 2;
        m_inner = d % 64;
      end else if (page == 6 && m_lock == 0) begin
        m_outer = d % 4;
        m_lock = (d / 128) % 2;
      end else if (page == 7 && m_lock == 0) begin
        m_chr = d % 16;
      end else if (page == 5 && rg == 0) begin
        m_latch = (m_latch / 256) * 256 + d;
      end else if (page == 5 && rg == 1) begin
        m_latch = d * 256 + (m_latch % 256);
      end
    end
  endtask

  function automatic int exp_prg(input int a);
    int hi;
    int a13;
    int idx;
    hi = (a / 16384) % 2;
    a13 = (a / 8192) % 2;
    case (m_mode)
      0: idx = (hi == 1) ? ((m_inner | 1) * 2 + a13) : (m_inner * 2 + a13);
      1: idx = (hi == 1) ? (63 * 2 + a13) : (m_inner * 2 + a13);
      2: idx = m_inner * 2 + m_lowbit;
      default: idx = m_inner * 2 + a13;
    endcase
    return m_outer * 1048576 + idx * 8192 + (a % 8192);
  endfunction

  function automatic int exp_chr(input int a, input int ram);
    if (ram != 0) return 2097152 + (a % 8192);
    return 2097152 + m_chr * 8192 + (a % 8192);
  endfunction

  task automatic drive(input int c, input int w, input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    bus.ce = c[0];
    bus.prg_write = w[0];
    bus.prg_read = ~w[0];
    bus.prg_ain = a;
    bus.prg_din = d;
    @(posedge clk);
    model_apply(c, w, int'(a), int'(d));
    #1;
    bus.ce = 1'b0;
    bus.prg_write = 1'b0;
    bus.prg_read = 1'b0;
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    drive(1, 1, a, d);
  endtask

  task automatic idle();
    drive(1, 0, 16'h0000, 8'h00);
  endtask

  task automatic read_at(input logic [15:0] a);
    @(negedge clk);
    bus.ce = 1'b0;
    bus.prg_write = 1'b0;
    bus.prg_ain = a;
    #1;
  endtask

  task automatic check_state(input string tag);
    check_val({tag, "_irq"}, 32'(bus.irq), 32'(m_irq));
    check_val({tag, "_prg_aout"}, 32'(bus.prg_aout), exp_prg(int'(bus.prg_ain)));
    check_val({tag, "_prg_allow"}, 32'(bus.prg_allow), 32'(bus.prg_ain[15] & ~bus.prg_write));
    check_val({tag, "_chr_aout"}, 32'(bus.chr_aout), exp_chr(int'(bus.chr_ain), int'(bus.flags[15])));
    check_val({tag, "_vram_a10"}, 32'(bus.vram_a10), 32'((m_mirr == 1) ? bus.chr_ain[11] : bus.chr_ain[10]));
    check_val({tag, "_vram_ce"}, 32'(bus.vram_ce), 32'(bus.chr_ain[13]));
    check_val({tag, "_chr_allow"}, 32'(bus.chr_allow), 32'(bus.flags[15]));
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    #2;
    model_reset();
    check_val("reset_irq", 32'(bus.irq), 32'h0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    logic [15:0] a;
    logic [7:0]  d;
    int          sel;
    bus.ce = 1'b0;
    bus.flags = 32'h0;
    bus.prg_ain = 16'h0;
    bus.prg_read = 1'b0;
    bus.prg_write = 1'b0;
    bus.prg_din = 8'h0;
    bus.chr_ain = 14'h0;
    model_reset();
    #12;
    reset = 1'b1;

    // scenario 1: reset state
    read_at(16'hC123);
    check_val("t1_prg_c123", 32'(bus.prg_aout), 32'h004123);
    check_val("t1_irq", 32'(bus.irq), 32'h0);
    bus.chr_ain = 14'h0400; #1;
    check_val("t1_a10_hi", 32'(bus.vram_a10), 32'h1);
    bus.chr_ain = 14'h0800; #1;
    check_val("t1_a10_lo", 32'(bus.vram_a10), 32'h0);
    check_state("t1");

    // scenario 2: mode1, mirroring, outer block
    wr(16'h8001, 8'h45);
    wr(16'h6000, 8'h02);
    read_at(16'h8000);
    check_val("t2_prg_8000", 32'(bus.prg_aout), 32'h214000);
    read_at(16'hC000);
    check_val("t2_prg_c000", 32'(bus.prg_aout), 32'h2FC000);
    bus.chr_ain = 14'h0800; #1;
    check_val("t2_a10_hi", 32'(bus.vram_a10), 32'h1);
    bus.chr_ain = 14'h0400; #1;
    check_val("t2_a10_lo", 32'(bus.vram_a10), 32'h0);
    check_state("t2");

    // scenario 3: lock freezes outer and chr_bank
    do_reset();
    wr(16'h6000, 8'h81);
    wr(16'h6000, 8'h03);
    wr(16'h7000, 8'h07);
    read_at(16'h8000);
    check_val("t3_outer_locked", 32'(bus.prg_aout), 32'h100000);
    bus.flags = 32'h0; bus.chr_ain = 14'h0000; #1;
    check_val("t3_chr_locked", 32'(bus.chr_aout), 32'h200000);
    check_state("t3");

    // scenario 4: CHR ROM bank vs CHR RAM
    do_reset();
    wr(16'h7000, 8'h05);
    bus.flags = 32'h0; bus.chr_ain = 14'h0ABC; #1;
    check_val("t4_chr_rom", 32'(bus.chr_aout), 32'h20AABC);
    bus.flags = 32'h8000; #1;
    check_val("t4_chr_ram", 32'(bus.chr_aout), 32'h200ABC);
    check_val("t4_chr_allow", 32'(bus.chr_allow), 32'h1);
    check_state("t4");

    // scenario 5: one-shot IRQ
    do_reset();
    wr(16'h5000, 8'h03);
    wr(16'h5001, 8'h00);
    wr(16'h5002, 8'h01);
    idle(); check_val("t5_irq_c1", 32'(bus.irq), 32'h0);
    idle(); check_val("t5_irq_c2", 32'(bus.irq), 32'h0);
    idle(); check_val("t5_irq_c3", 32'(bus.irq), 32'h1);
    for (int i = 0; i < 5; i++) idle();
    check_val("t5_irq_sticky", 32'(bus.irq), 32'h1);
    wr(16'h5003, 8'h00);
    check_val("t5_irq_ack", 32'(bus.irq), 32'h0);
    for (int i = 0; i < 5; i++) idle();
    check_val("t5_irq_oneshot", 32'(bus.irq), 32'h0);
    check_state("t5");

    // scenario 6: auto-reload, ack vs terminal, async reset
    do_reset();
    wr(16'h5000, 8'h02);
    wr(16'h5002, 8'h03);
    idle(); check_val("t6_irq_c1", 32'(bus.irq), 32'h0);
    idle(); check_val("t6_irq_c2", 32'(bus.irq), 32'h1);
    wr(16'h5003, 8'h00); check_val("t6_ack", 32'(bus.irq), 32'h0);
    wr(16'h5003, 8'h00); check_val("t6_ack_vs_terminal", 32'(bus.irq), 32'h1);
    idle();
    check_state("t6");
    reset = 1'b0;
    #1;
    check_val("t6_async_reset_irq", 32'(bus.irq), 32'h0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;

    // randomized traffic against the reference model
    for (int i = 0; i < 4000; i++) begin
      sel = $urandom_range(0, 9);
      d = 8'($urandom);
      case (sel)
        0, 1, 2: a = 16'h8000 | 16'($urandom);
        3: begin
          a = 16'h6000 | 16'($urandom_range(0, 4095));
          d[7] = ($urandom_range(0, 15) == 0);
        end
        4: a = 16'h7000 | 16'($urandom_range(0, 4095));
        5, 6, 7: begin
          a = 16'h5000 | (16'($urandom_range(0, 255)) << 4) | 16'($urandom_range(0, 3));
          if (a[3:0] == 4'h0) d = 8'($urandom_range(0, 6));
          if (a[3:0] == 4'h1 && $urandom_range(0, 7) != 0) d = 8'h00;
        end
        8: a = 16'($urandom);
        default: a = 16'h5000 | 16'($urandom_range(4, 4095));
      endcase
      drive(($urandom_range(0, 7) != 0) ? 1 : 0, ($urandom_range(0, 2) == 0) ? 1 : 0, a, d);
      bus.prg_ain = 16'($urandom);
      bus.chr_ain = 14'($urandom);
      bus.flags = $urandom;
      #1;
      check_state($sformatf("rnd%0d", i));
      if (i % 700 == 699) begin
        reset = 1'b0;
        #1;
        check_val("rnd_async_reset_irq", 32'(bus.irq), 32'h0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
